// File: rtl/frame_row_capture.sv
// Captures a serialized 8x8 one-bit frame into rows of eight pixels and queues
// each completed {row number, row byte} in a small FIFO for a downstream consumer.
module frame_row_capture #(
    parameter int START_DELAY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pixel_in,
    input  logic       frame_sync,
    output logic [7:0] row_data,
    output logic [2:0] row_idx,
    output logic       row_valid,
    input  logic       row_ready,
    output logic       frame_done,
    output logic       busy,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

    state_t      state, state_nx;
    logic [1:0]  dly_cnt, dly_nx;
    logic [5:0]  pix_cnt, pix_nx;
    logic [7:0]  asm_q, asm_nx;
    logic        push_q, push_nx;
    logic [10:0] push_word_q, push_word_nx;
    logic        done_q, done_nx;
    logic        sample_en;
    logic        restart;
    logic [7:0]  row_bits;

    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, push_ok;

    logic unused_pix;
    assign unused_pix = ^pixel_in[3:1];

    // The final WAIT cycle (counter at 0) already takes sample 0, so the first
    // sample lands exactly START_DELAY cycles after the frame_sync cycle.
    assign sample_en = (state == CAPTURE) || (state == WAIT && dly_cnt == 2'd0);
    assign restart   = frame_sync && (state != IDLE);

    always_comb begin
        state_nx     = state;
        dly_nx       = dly_cnt;
        pix_nx       = pix_cnt;
        asm_nx       = asm_q;
        push_nx      = 1'b0;
        push_word_nx = push_word_q;
        done_nx      = 1'b0;
        row_bits     = asm_q | ({7'b0, pixel_in[0]} << pix_cnt[2:0]);

        case (state)
            IDLE: begin
                if (frame_sync) begin
                    state_nx = WAIT;
                    dly_nx   = 2'(START_DELAY - 1);
                    pix_nx   = '0;
                    asm_nx   = '0;
                end
            end
            WAIT: begin
                if (dly_cnt != 2'd0) dly_nx = dly_cnt - 2'd1;
                else                 state_nx = CAPTURE;
            end
            CAPTURE: ;
            default: state_nx = IDLE;
        endcase

        if (sample_en) begin
            pix_nx = pix_cnt + 6'd1;
            if (pix_cnt[2:0] == 3'd7) begin
                push_nx      = 1'b1;
                push_word_nx = {pix_cnt[5:3], row_bits};
                asm_nx       = '0;
            end else begin
                asm_nx = row_bits;
            end
            if (pix_cnt == 6'd63) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
        end

        // A restart keeps any row completed this cycle but drops the partial one.
        if (restart) begin
            state_nx = WAIT;
            dly_nx   = 2'(START_DELAY - 1);
            pix_nx   = '0;
            asm_nx   = '0;
            done_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dly_cnt     <= '0;
            pix_cnt     <= '0;
            asm_q       <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            dly_cnt     <= dly_nx;
            pix_cnt     <= pix_nx;
            asm_q       <= asm_nx;
            push_q      <= push_nx;
            push_word_q <= push_word_nx;
            done_q      <= done_nx;
        end
    end

    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = row_valid && row_ready;
    assign push_ok = push_q && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_word_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_q && full && !pop) overflow <= 1'b1;
        end
    end

    assign row_valid  = (count != '0);
    assign row_data   = row_valid ? mem[rd_ptr][7:0]  : '0;
    assign row_idx    = row_valid ? mem[rd_ptr][10:8] : '0;
    assign frame_done = done_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_frame_row_capture.sv
// Directed bench for frame_row_capture: one instance with START_DELAY=1 and one
// with START_DELAY=3, both with a 4-row FIFO.
module tb_frame_row_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] pix1, pix3;
    logic       fs1, fs3, rdy1, rdy3;
    logic [7:0] rd1, rd3;
    logic [2:0] ri1, ri3;
    logic       rv1, rv3, fd1, fd3, bz1, bz3, ov1, ov3;

    frame_row_capture #(.START_DELAY(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .pixel_in(pix1), .frame_sync(fs1),
        .row_data(rd1), .row_idx(ri1), .row_valid(rv1), .row_ready(rdy1),
        .frame_done(fd1), .busy(bz1), .overflow(ov1)
    );

    frame_row_capture #(.START_DELAY(3), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst(rst), .pixel_in(pix3), .frame_sync(fs3),
        .row_data(rd3), .row_idx(ri3), .row_valid(rv3), .row_ready(rdy3),
        .frame_done(fd3), .busy(bz3), .overflow(ov3)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        sel3;
    int          cn;
    int          first_valid;
    int          done_cnt;
    logic [10:0] got[$];

    localparam logic [63:0] B1  = 64'h8000_0000_0000_0201;
    localparam logic [63:0] B3A = 64'h0000_0000_0008_0201;
    localparam logic [63:0] B3B = 64'h8040_2010_0804_0201;
    localparam logic [63:0] B4  = 64'h8877_6655_4433_2211;
    localparam logic [63:0] B6  = 64'h0000_0000_0000_0001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus on the selected instance; records pops,
    // first row_valid cycle and frame_done pulses for that instance.
    task automatic cyc(input logic fs, input logic px, input logic rdy);
        if (sel3) begin
            fs3 = fs; pix3 = {3'b101, px}; rdy3 = rdy;
            fs1 = 1'b0; pix1 = 4'b0; rdy1 = 1'b0;
        end else begin
            fs1 = fs; pix1 = {3'b110, px}; rdy1 = rdy;
            fs3 = 1'b0; pix3 = 4'b0; rdy3 = 1'b0;
        end
        #1;
        if (sel3 ? (rv3 && rdy3) : (rv1 && rdy1))
            got.push_back(sel3 ? {ri3, rd3} : {ri1, rd1});
        if ((sel3 ? rv3 : rv1) && first_valid < 0) first_valid = cn;
        if (sel3 ? fd3 : fd1) done_cnt++;
        @(posedge clk);
        #1;
        cn++;
    endtask

    task automatic start();
        got.delete();
        first_valid = -1;
        done_cnt    = 0;
        cn          = 0;
    endtask

    task automatic run_bits(input logic [63:0] b, input logic rdy);
        for (int k = 0; k < 64; k++) cyc(1'b0, b[k], rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, rdy);
    endtask

    task automatic check_rows(input string tag, input int base, input int first_row,
                              input int nrows, input logic [63:0] b);
        logic [31:0] obs;
        logic [2:0]  idx;
        for (int r = first_row; r < first_row + nrows; r++) begin
            int p;
            p   = base + r - first_row;
            obs = (p < got.size()) ? {21'b0, got[p]} : 32'hDEAD;
            idx = r[2:0];
            chk($sformatf("%s_row%0d", tag, r), obs, {21'b0, idx, b[8*r +: 8]});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        chk("in_reset1", {rv1, fd1, bz1, ov1, ri1, rd1}, 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("reset1", {rv1, fd1, bz1, ov1, ri1, rd1}, 32'h0);
        chk("reset3", {rv3, fd3, bz3, ov3, ri3, rd3}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; sel3 = 1'b0;
        fs1 = 1'b0; fs3 = 1'b0; pix1 = 4'b0; pix3 = 4'b0; rdy1 = 1'b0; rdy3 = 1'b0;
        start();
        do_reset();

        // Basic frame with three set pixels, consumer always ready
        start();
        cyc(1'b1, 1'b0, 1'b1);
        run_bits(B1, 1'b1);
        idle(12, 1'b1);
        chk("t1_nrows", got.size(), 32'd8);
        check_rows("t1", 0, 0, 8, B1);
        chk("t1_latency", first_valid, 32'd10);
        chk("t1_done", done_cnt, 32'd1);
        chk("t1_ovf", ov1, 1'b0);
        chk("t1_busy", bz1, 1'b0);

        // All-ones frame into a stalled consumer: rows 4..7 dropped
        do_reset();
        start();
        cyc(1'b1, 1'b0, 1'b0);
        run_bits('1, 1'b0);
        idle(12, 1'b0);
        chk("t2_valid", rv1, 1'b1);
        chk("t2_ovf", ov1, 1'b1);
        chk("t2_done", done_cnt, 32'd1);
        idle(4, 1'b1);
        chk("t2_nrows", got.size(), 32'd4);
        check_rows("t2", 0, 0, 4, '1);
        chk("t2_empty", rv1, 1'b0);
        chk("t2_ovf_sticky", ov1, 1'b1);

        // Restart at pix_cnt=20: rows 0,1 kept, then a fresh frame
        do_reset();
        start();
        cyc(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) cyc(1'b0, B3A[k], 1'b1);
        cyc(1'b1, B3A[20], 1'b1);
        run_bits(B3B, 1'b1);
        idle(12, 1'b1);
        chk("t3_nrows", got.size(), 32'd10);
        check_rows("t3a", 0, 0, 2, B3A);
        check_rows("t3b", 2, 0, 8, B3B);
        chk("t3_done", done_cnt, 32'd1);
        chk("t3_ovf", ov1, 1'b0);

        // Full FIFO with push and pop in the same cycle for rows 4..7
        do_reset();
        start();
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 64; k++) cyc(1'b0, B4[k], (k == 40 || k == 48 || k == 56));
        cyc(1'b0, 1'b0, 1'b1);
        idle(6, 1'b0);
        chk("t4_npopped", got.size(), 32'd4);
        check_rows("t4a", 0, 0, 4, B4);
        chk("t4_ovf", ov1, 1'b0);
        chk("t4_valid", rv1, 1'b1);
        got.delete();
        idle(6, 1'b1);
        chk("t4_nheld", got.size(), 32'd4);
        check_rows("t4b", 0, 4, 4, B4);
        chk("t4_empty", rv1, 1'b0);

        // Reset mid-frame at pix_cnt=40, with frame_sync in the reset cycle
        do_reset();
        start();
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) cyc(1'b0, 1'b1, 1'b0);
        chk("t5_pre_valid", rv1, 1'b1);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        chk("t5_busy", bz1, 1'b0);
        chk("t5_valid", rv1, 1'b0);
        chk("t5_rest", {fd1, ov1, ri1, rd1}, 32'h0);
        idle(1, 1'b0);
        chk("t5_busy_after", bz1, 1'b0);
        start();
        cyc(1'b1, 1'b0, 1'b1);
        run_bits(B4, 1'b1);
        idle(12, 1'b1);
        chk("t5_nrows", got.size(), 32'd8);
        check_rows("t5", 0, 0, 8, B4);
        chk("t5_done", done_cnt, 32'd1);

        // START_DELAY=3: only the pixel at frame_sync+3 lands in row 0
        sel3 = 1'b1;
        do_reset();
        start();
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        for (int k = 1; k < 64; k++) cyc(1'b0, 1'b0, 1'b1);
        idle(12, 1'b1);
        chk("t6_nrows", got.size(), 32'd8);
        check_rows("t6", 0, 0, 8, B6);
        chk("t6_latency", first_valid, 32'd12);
        chk("t6_done", done_cnt, 32'd1);
        chk("t6_ovf", ov3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_row_capture.md
FRAME_ROW_CAPTURE -- requirements
Module: frame_row_capture

Interface
REQ-001 SHALL have parameter START_DELAY, default 1, giving the cycles from the frame_sync-high cycle to the first pixel sample; legal range 1..4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the row FIFO depth in rows; a power of two, 2..8.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port pixel_in  input  4  serialized pixel stream; only bit 0 is sampled, bits 3:1 are ignored.
REQ-006 SHALL have port frame_sync  input  1  frame start strobe from the rasterizer.
REQ-007 SHALL have port row_data  output  8  FIFO head row; bit x is pixel x.
REQ-008 SHALL have port row_idx  output  3  row number y of the FIFO head.
REQ-009 SHALL have port row_valid  output  1  high when the FIFO is not empty.
REQ-010 SHALL have port row_ready  input  1  consumer accept; a pop occurs when row_valid and row_ready are both high.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at frame completion.
REQ-012 SHALL have port busy  output  1  high while in WAIT or CAPTURE.
REQ-013 SHALL have port overflow  output  1  sticky flag set when a completed row is dropped.

Function
REQ-014 SHALL implement the states IDLE, WAIT and CAPTURE.
REQ-015 SHALL move from IDLE to WAIT on any cycle where frame_sync=1, loading the delay counter with START_DELAY-1.
REQ-016 SHALL decrement the delay counter in WAIT and enter CAPTURE when the counter is 0, so that the first sample is taken exactly START_DELAY cycles after the frame_sync cycle.
REQ-017 SHALL, in CAPTURE, sample pixel_in[0] every cycle into shift/assembly bit x = pix_cnt[2:0] of row y = pix_cnt[5:3], where pix_cnt is a 6-bit counter that starts at 0.
REQ-018 SHALL, on the sample with pix_cnt[2:0]=7, push the assembled {y, row byte} into the FIFO in the following cycle (one-cycle push latency) and clear the assembly register.
REQ-019 SHALL, on the sample with pix_cnt=63, return to IDLE and pulse frame_done high for exactly one cycle, coincident with the push of row 7.
REQ-020 SHALL treat frame_sync=1 during WAIT or CAPTURE as a restart: discard the partial row, reset pix_cnt to 0, and re-enter WAIT; rows already pushed are kept and frame_done does not pulse.
REQ-021 SHALL act on the restart if frame_sync=1 coincides with the pix_cnt=63 sample: the restart wins, row 7 is still pushed, and frame_done does not pulse.
REQ-022 SHALL implement the FIFO with FIFO_DEPTH entries, wrap-around pointers, and an occupancy counter of width clog2(FIFO_DEPTH)+1.
REQ-023 SHALL drive row_data and row_idx from the FIFO head combinationally; their values are don't-care when row_valid=0.
REQ-024 SHALL accept a push when the FIFO is full only if a pop occurs in the same cycle; occupancy stays at FIFO_DEPTH.
REQ-025 SHALL, on a push while full with no pop, drop the row, leave the FIFO unchanged and set overflow, which stays high until rst.
REQ-026 SHALL decrement occupancy on a pop from a non-empty FIFO and ignore a pop when the FIFO is empty.
REQ-027 SHALL leave occupancy unchanged on a simultaneous push and pop with the FIFO neither empty nor full.
REQ-028 SHALL, on a push to an empty FIFO, assert row_valid in the cycle after the push (no fall-through).
REQ-029 SHALL have a latency from the frame_sync cycle to row 0 visible on row_valid of START_DELAY+9 cycles, provided the FIFO is not full.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, go to IDLE and clear pix_cnt, the delay counter, the assembly register, the FIFO pointers and occupancy.
REQ-031 SHALL, during and after reset, drive row_valid=0, frame_done=0, busy=0, overflow=0, row_data=0 and row_idx=0.
REQ-032 SHALL discard all captured state on rst mid-frame and ignore frame_sync in the same cycle as rst.

Verification
REQ-033 SHALL pass this case: with START_DELAY=1 and row_ready=1, pulse frame_sync, then drive pixel_in[0]=1 only at k=0, 9 and 63 -> rows 0..7 read 0x01, 0x02, 0x00, 0x00, 0x00, 0x00, 0x00, 0x80 with row_idx 0..7, frame_done pulses once, overflow=0.
REQ-034 SHALL pass this case: with row_ready=0, send a full all-ones frame with FIFO_DEPTH=4 -> rows 0..3 = 0xFF held, rows 4..7 dropped, overflow=1, and overflow is still 1 after 4 pops.
REQ-035 SHALL pass this case: assert frame_sync again at pix_cnt=20 -> rows 0 and 1 of the first frame are kept, then a fresh 8 rows arrive, with only one frame_done pulse.
REQ-036 SHALL pass this case: FIFO full, with a row push and a pop in the same cycle -> push accepted, occupancy stays 4, overflow=0.
REQ-037 SHALL pass this case: assert rst at pix_cnt=40 -> next cycle busy=0 and row_valid=0; a subsequent frame captures correctly.
REQ-038 SHALL pass this case: with START_DELAY=3 and pixel_in[0]=1 only at the cycle frame_sync+3 -> row 0 = 0x01; a 1 driven at frame_sync+2 is ignored.
